// File: rtl/wb_stage.sv
// wb_stage: merges ALU and buffered long-latency results into one RF write port.
// Optional macro WB_FWD_EN adds a bypass of the value committing this cycle.
module wb_stage #(
    parameter int B_DEPTH      = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [4:0]               a_rd,
    input  logic [63:0]              a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [4:0]               b_rd,
    input  logic [63:0]              b_data,
    output logic [$clog2(B_DEPTH):0] b_pending,
`ifdef WB_FWD_EN
    input  logic [4:0]               fwd_rs1,
    input  logic [4:0]               fwd_rs2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [63:0]              fwd_data,
`endif
    output logic                     rf_en,
    output logic                     rf_we,
    output logic [4:0]               rf_rd,
    output logic [63:0]              rf_wdata
);

    localparam int PW = $clog2(B_DEPTH);
    localparam logic [PW:0] DEPTH = (PW+1)'(B_DEPTH);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [4:0]    q_rd   [B_DEPTH];
    logic [63:0]   q_data [B_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [7:0]    starve_cnt;

    logic        starve_mode;
    logic        empty;
    logic        a_fire;
    logic        b_push;
    logic        pop;
    logic        sel;
    logic [4:0]  sel_rd;
    logic [63:0] sel_data;

    assign empty       = (count == '0);
    assign starve_mode = (starve_cnt >= LIMIT);
    assign a_ready     = ~starve_mode;
    assign b_ready     = (count < DEPTH);
    assign a_fire      = a_valid & a_ready;
    assign b_push      = b_valid & b_ready;
    assign b_pending   = count;
    assign rf_en       = rf_we & ~clk;

    // Pick one result: a starving head first, then ALU, then any head.
    always_comb begin
        pop      = 1'b0;
        sel      = 1'b0;
        sel_rd   = a_rd;
        sel_data = a_data;
        if (starve_mode && !empty) begin
            pop      = 1'b1;
            sel      = 1'b1;
            sel_rd   = q_rd[rd_ptr];
            sel_data = q_data[rd_ptr];
        end else if (a_fire) begin
            sel = 1'b1;
        end else if (!empty) begin
            pop      = 1'b1;
            sel      = 1'b1;
            sel_rd   = q_rd[rd_ptr];
            sel_data = q_data[rd_ptr];
        end
    end

    // FIFO storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (b_push) begin
            q_rd[wr_ptr]   <= b_rd;
            q_data[wr_ptr] <= b_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (b_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            case ({b_push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Saturating count of cycles the head has been left waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (empty || pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != 8'hFF) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // Commit register; x0 results are consumed without a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else if (sel && (sel_rd != 5'd0)) begin
            rf_we    <= 1'b1;
            rf_rd    <= sel_rd;
            rf_wdata <= sel_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

`ifdef WB_FWD_EN
    assign fwd_hit1 = rf_we & (fwd_rs1 == rf_rd) & (fwd_rs1 != 5'd0);
    assign fwd_hit2 = rf_we & (fwd_rs2 == rf_rd) & (fwd_rs2 != 5'd0);
    assign fwd_data = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized scoreboard bench for wb_stage.
// Reference model works on a queue of buffered results and a wait counter.
module tb_wb_stage;

    localparam int B_DEPTH      = 4;
    localparam int STARVE_LIMIT = 8;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } ent_t;

    logic                     clk;
    logic                     rst_n;
    logic                     a_valid;
    logic                     a_ready;
    logic [4:0]               a_rd;
    logic [63:0]              a_data;
    logic                     b_valid;
    logic                     b_ready;
    logic [4:0]               b_rd;
    logic [63:0]              b_data;
    logic [$clog2(B_DEPTH):0] b_pending;
    logic                     rf_en;
    logic                     rf_we;
    logic [4:0]               rf_rd;
    logic [63:0]              rf_wdata;
`ifdef WB_FWD_EN
    logic [4:0]               fwd_rs1;
    logic [4:0]               fwd_rs2;
    logic                     fwd_hit1;
    logic                     fwd_hit2;
    logic [63:0]              fwd_data;
`endif

    wb_stage #(
        .B_DEPTH(B_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .a_valid(a_valid),
        .a_ready(a_ready),
        .a_rd(a_rd),
        .a_data(a_data),
        .b_valid(b_valid),
        .b_ready(b_ready),
        .b_rd(b_rd),
        .b_data(b_data),
        .b_pending(b_pending),
`ifdef WB_FWD_EN
        .fwd_rs1(fwd_rs1),
        .fwd_rs2(fwd_rs2),
        .fwd_hit1(fwd_hit1),
        .fwd_hit2(fwd_hit2),
        .fwd_data(fwd_data),
`endif
        .rf_en(rf_en),
        .rf_we(rf_we),
        .rf_rd(rf_rd),
        .rf_wdata(rf_wdata)
    );

    int   nchecks = 0;
    int   nerr    = 0;
    ent_t bq[$];
    ent_t expq[$];
    int   waitc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        nchecks++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // One clock of stimulus plus one step of the reference model.
    task automatic cycle(input bit av, input logic [4:0] ard,
                         input logic [63:0] ad, input bit bv,
                         input logic [4:0] brd, input logic [63:0] bd,
                         output bit af, output bit bf);
        bit   m_ar;
        bit   m_br;
        bit   have;
        bit   popped;
        bit   nonempty;
        ent_t s;
        @(negedge clk);
        m_ar = !(waitc >= STARVE_LIMIT);
        m_br = bq.size() < B_DEPTH;
        chk("a_ready", a_ready, m_ar);
        chk("b_ready", b_ready, m_br);
        chk("b_pending", b_pending, bq.size());
        a_valid = av;
        a_rd    = ard;
        a_data  = ad;
        b_valid = bv;
        b_rd    = brd;
        b_data  = bd;
        af       = av && m_ar;
        bf       = bv && m_br;
        nonempty = bq.size() > 0;
        have     = 0;
        popped   = 0;
        if (!m_ar && nonempty) begin
            s = bq.pop_front(); have = 1; popped = 1;
        end else if (af) begin
            s.rd = ard; s.data = ad; have = 1;
        end else if (nonempty) begin
            s = bq.pop_front(); have = 1; popped = 1;
        end
        if (!nonempty || popped) waitc = 0;
        else if (waitc < 255) waitc++;
        if (bf) begin
            ent_t n;
            n.rd = brd; n.data = bd;
            bq.push_back(n);
        end
        if (have && s.rd != 5'd0) expq.push_back(s);
    endtask

    task automatic idle(input int n);
        bit af, bf;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, af, bf);
    endtask

    // Monitor: compares every commit against the oldest expectation.
    initial begin : monitor
        ent_t e;
`ifdef WB_FWD_EN
        fwd_rs1 = 0;
        fwd_rs2 = 0;
`endif
        forever begin
            @(posedge clk); #1;
            chk("rf_en_clk_high", rf_en, 0);
`ifdef WB_FWD_EN
            fwd_rs2 = 5'd0;
            if (expq.size() > 0 && ($urandom % 2) == 1) fwd_rs1 = expq[0].rd;
            else fwd_rs1 = 5'($urandom);
`endif
            @(negedge clk); #1;
            if (rf_we === 1'b1) begin
                if (expq.size() == 0) begin
                    nchecks++;
                    nerr++;
                    $display("FAIL unexpected_commit: got rd %0d data %h expected none",
                             rf_rd, rf_wdata);
                end else begin
                    e = expq.pop_front();
                    chk("rf_rd", rf_rd, e.rd);
                    chk("rf_wdata", rf_wdata, e.data);
                    chk("rf_en_pulse", rf_en, 1);
`ifdef WB_FWD_EN
                    chk("fwd_hit1", fwd_hit1, (fwd_rs1 == e.rd) && (e.rd != 0));
                    chk("fwd_hit2", fwd_hit2, 0);
                    chk("fwd_data", fwd_data, e.data);
`endif
                end
            end else begin
                chk("rf_en_idle", rf_en, 0);
            end
        end
    end

    initial begin : driver
        bit          af, bf;
        bit          ah, bh;
        bit          av, bv;
        logic [4:0]  ard, brd;
        logic [63:0] ad, bd;
        int          pa, pb;
        rst_n   = 1'b0;
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        #3;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_rf_en", rf_en, 0);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_b_ready", b_ready, 1);
        chk("rst_b_pending", b_pending, 0);
        #9 rst_n = 1'b1;

        cycle(1, 5, 64'h1122334455667788, 0, 0, 0, af, bf);
        idle(3);

        for (int i = 1; i <= 4; i++)
            cycle(0, 0, 0, 1, 5'(i), 64'(i) * 64'h101, af, bf);
        idle(6);

        brd = 5'd16; bd = 64'hB000;
        for (int i = 0; i < 24; i++) begin
            cycle(1, 5'(1 + i % 15), 64'hA000 + 64'(i), 1, brd, bd, af, bf);
            if (bf) begin brd = brd + 5'd1; bd = bd + 64'd1; end
        end
        idle(8);

        cycle(1, 0, 64'hFFFF, 0, 0, 0, af, bf);
        cycle(0, 0, 0, 1, 0, 64'hEEEE, af, bf);
        idle(4);

        cycle(1, 7, 64'hABCD, 0, 0, 0, af, bf);
        idle(2);

        for (int i = 0; i < 3; i++)
            cycle(1, 5'(10 + i), 64'hC0 + 64'(i), 1, 5'(20 + i), 64'hD0 + 64'(i), af, bf);
        @(posedge clk); #2;
        chk("pre_rst_rf_we", rf_we, expq.size() > 0);
        chk("pre_rst_pending", b_pending, bq.size());
        rst_n   = 1'b0;
        a_valid = 0;
        b_valid = 0;
        #1;
        chk("mid_rst_rf_we", rf_we, 0);
        chk("mid_rst_rf_rd", rf_rd, 0);
        chk("mid_rst_rf_wdata", rf_wdata, 0);
        chk("mid_rst_rf_en", rf_en, 0);
        chk("mid_rst_pending", b_pending, 0);
        chk("mid_rst_a_ready", a_ready, 1);
        chk("mid_rst_b_ready", b_ready, 1);
        bq.delete();
        expq.delete();
        waitc = 0;
        @(negedge clk); #2 rst_n = 1'b1;
        idle(6);

        ah = 0; bh = 0;
        av = 0; bv = 0; ard = 0; brd = 0; ad = 0; bd = 0;
        pa = 50; pb = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                pa = $urandom_range(10, 100);
                pb = $urandom_range(10, 100);
            end
            if (!ah) begin
                av  = ($urandom % 100) < pa;
                ard = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
                ad  = {$urandom(), $urandom()};
            end
            if (!bh) begin
                bv  = ($urandom % 100) < pb;
                brd = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
                bd  = {$urandom(), $urandom()};
            end
            cycle(av, ard, ad, bv, brd, bd, af, bf);
            ah = av && !af;
            bh = bv && !bf;
        end
        idle(12);
        chk("drained_expectations", 64'(expq.size()), 0);
        chk("drained_fifo", b_pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
